// File: rtl/mc_ctrl_pkg.sv
// Shared control codes for the multi-cycle MIPS controller: state encodings, opcodes,
// ALU operation selects and datapath mux selects used by the control FSM, ALU control and datapath.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_R_EXEC   = 4'd3,
        ST_R_WB     = 4'd4,
        ST_I_EXEC   = 4'd5,
        ST_I_WB     = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_LW_WB    = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_JAL      = 4'd13
    } state_t;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_RTYPE = 6'b000000;
    localparam opcode_t OP_J     = 6'b000010;
    localparam opcode_t OP_JAL   = 6'b000011;
    localparam opcode_t OP_BEQ   = 6'b000100;
    localparam opcode_t OP_ADDI  = 6'b001000;
    localparam opcode_t OP_ORI   = 6'b001101;
    localparam opcode_t OP_LW    = 6'b100011;
    localparam opcode_t OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_OP_FUNCT = 2'b00;
    localparam logic [1:0] ALU_OP_ADD   = 2'b01;
    localparam logic [1:0] ALU_OP_OR    = 2'b10;
    localparam logic [1:0] ALU_OP_SUB   = 2'b11;

    localparam logic [1:0] ALU_SRC_B_RT      = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_SRC_B_IMM_SL2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // States that wait on the memory ready handshake and therefore run the timeout counter.
    function automatic logic is_mem_wait(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_mem_timeout.sv
// Memory-wait timeout: counts consecutive not-ready cycles in a waiting state and raises a
// sticky error on the MEM_TMO-th such cycle; ready in that same cycle still completes normally.
module mc_mem_timeout #(
    parameter int TMO_W   = 4,
    parameter int MEM_TMO = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic wait_active,
    input  logic mem_ready,
    output logic timeout,
    output logic mem_err
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TMO - 1);

    logic [TMO_W-1:0] wait_cnt;

    assign timeout = wait_active && !mem_ready && (wait_cnt == TMO_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            if (wait_active && !mem_ready && !timeout) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (timeout) begin
                mem_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM driving the shared-memory datapath enables each cycle.
// Optional JAL support is compiled in when the JAL_EN macro is defined.
//
// state     | meaning
// IDLE      | waiting for start_i
// FETCH     | read instruction at PC, PC+4, wait for mem_ready_i
// DECODE    | register read, branch target into ALUOut
// R_EXEC    | R-type ALU operation
// R_WB      | write ALUOut to rd
// I_EXEC    | addi/ori ALU operation with immediate
// I_WB      | write ALUOut to rt
// MEM_ADDR  | lw/sw effective address
// MEM_RD    | data read, wait for mem_ready_i
// MEM_WR    | data write, wait for mem_ready_i
// LW_WB     | write MDR to rt
// BRANCH    | beq compare, conditional PC load
// JUMP      | PC load from jump target
// JAL       | PC load from jump target, link PC+4 into $31
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int TMO_W   = 4,
    parameter int MEM_TMO = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [OP_W-1:0] op_i,
    input  logic            mem_ready_i,
    output logic            pc_write_o,
    output logic            pc_write_cond_o,
    output logic [1:0]      pc_src_o,
    output logic            iord_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            ir_write_o,
    output logic            reg_dst_o,
    output logic            mem_to_reg_o,
    output logic            reg_write_o,
    output logic            alu_src_a_o,
    output logic [1:0]      alu_src_b_o,
    output logic [1:0]      alu_op_o,
    output logic            illegal_o,
    output logic            mem_err_o,
`ifdef JAL_EN
    output logic            jal_link_o,
`endif
    output logic [3:0]      state_o
);

    state_t  state;
    state_t  state_next;
    opcode_t opcode;
    logic    decode_illegal;
    logic    mem_timeout;

    assign opcode  = opcode_t'(op_i);
    assign state_o = state;

    mc_mem_timeout #(
        .TMO_W   (TMO_W),
        .MEM_TMO (MEM_TMO)
    ) u_mem_timeout (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wait_active (is_mem_wait(state)),
        .mem_ready   (mem_ready_i),
        .timeout     (mem_timeout),
        .mem_err     (mem_err_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            illegal_o <= 1'b0;
        end else begin
            state     <= state_next;
            illegal_o <= decode_illegal;
        end
    end

    always_comb begin
        state_next     = state;
        decode_illegal = 1'b0;
        case (state)
            ST_IDLE:     if (start_i) state_next = ST_FETCH;
            ST_FETCH: begin
                if (mem_timeout)      state_next = ST_IDLE;
                else if (mem_ready_i) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:       state_next = ST_R_EXEC;
                    OP_ADDI, OP_ORI: state_next = ST_I_EXEC;
                    OP_LW, OP_SW:   state_next = ST_MEM_ADDR;
                    OP_BEQ:         state_next = ST_BRANCH;
                    OP_J:           state_next = ST_JUMP;
`ifdef JAL_EN
                    OP_JAL:         state_next = ST_JAL;
`endif
                    default: begin
                        state_next     = ST_FETCH;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            ST_R_EXEC:   state_next = ST_R_WB;
            ST_I_EXEC:   state_next = ST_I_WB;
            ST_MEM_ADDR: state_next = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_timeout)      state_next = ST_IDLE;
                else if (mem_ready_i) state_next = ST_LW_WB;
            end
            ST_MEM_WR: begin
                if (mem_timeout)      state_next = ST_IDLE;
                else if (mem_ready_i) state_next = ST_FETCH;
            end
            ST_R_WB, ST_I_WB, ST_LW_WB, ST_BRANCH, ST_JUMP, ST_JAL: state_next = ST_FETCH;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Only FETCH looks at mem_ready_i directly: IR and PC load in the cycle the read completes.
    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_src_o        = PC_SRC_ALU;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = ALU_SRC_B_RT;
        alu_op_o        = ALU_OP_FUNCT;
`ifdef JAL_EN
        jal_link_o      = 1'b0;
`endif
        case (state)
            ST_FETCH: begin
                mem_read_o  = 1'b1;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                alu_src_b_o = ALU_SRC_B_FOUR;
                alu_op_o    = ALU_OP_ADD;
            end
            ST_DECODE: begin
                alu_src_b_o = ALU_SRC_B_IMM_SL2;
                alu_op_o    = ALU_OP_ADD;
            end
            ST_R_EXEC: begin
                alu_src_a_o = 1'b1;
            end
            ST_R_WB: begin
                reg_dst_o   = 1'b1;
                reg_write_o = 1'b1;
            end
            ST_I_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = ALU_SRC_B_IMM;
                alu_op_o    = (opcode == OP_ORI) ? ALU_OP_OR : ALU_OP_ADD;
            end
            ST_I_WB:     reg_write_o = 1'b1;
            ST_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = ALU_SRC_B_IMM;
                alu_op_o    = ALU_OP_ADD;
            end
            ST_MEM_RD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
            end
            ST_LW_WB: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALU_OP_SUB;
                pc_write_cond_o = 1'b1;
                pc_src_o        = PC_SRC_ALUOUT;
            end
            ST_JUMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = PC_SRC_JUMP;
            end
`ifdef JAL_EN
            ST_JAL: begin
                pc_write_o  = 1'b1;
                pc_src_o    = PC_SRC_JUMP;
                reg_write_o = 1'b1;
                jal_link_o  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through its state
// sequence and checks state and all control outputs against hand-derived values.
module tb_multicycle_control;
    import mc_ctrl_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [5:0] op_i;
    logic       mem_ready_i;
    logic       pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o, ir_write_o;
    logic       reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, illegal_o, mem_err_o;
    logic [1:0] pc_src_o, alu_src_b_o, alu_op_o;
    logic [3:0] state_o;
`ifdef JAL_EN
    logic       jal_link_o;
`endif

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .op_i            (op_i),
        .mem_ready_i     (mem_ready_i),
        .pc_write_o      (pc_write_o),
        .pc_write_cond_o (pc_write_cond_o),
        .pc_src_o        (pc_src_o),
        .iord_o          (iord_o),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .ir_write_o      (ir_write_o),
        .reg_dst_o       (reg_dst_o),
        .mem_to_reg_o    (mem_to_reg_o),
        .reg_write_o     (reg_write_o),
        .alu_src_a_o     (alu_src_a_o),
        .alu_src_b_o     (alu_src_b_o),
        .alu_op_o        (alu_op_o),
        .illegal_o       (illegal_o),
        .mem_err_o       (mem_err_o),
`ifdef JAL_EN
        .jal_link_o      (jal_link_o),
`endif
        .state_o         (state_o)
    );

    always #5 clk_i = ~clk_i;

    logic [15:0] ctl_obs;
    assign ctl_obs = {pc_write_o, pc_write_cond_o, pc_src_o, iord_o, mem_read_o, mem_write_o,
                      ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o,
                      alu_src_b_o, alu_op_o};

    function automatic logic [15:0] ctl(input int pcw, input int pcc, input int pcs, input int iord,
                                        input int mr, input int mw, input int irw, input int rd,
                                        input int m2r, input int rw, input int sa, input int sb,
                                        input int op);
        return {1'(pcw), 1'(pcc), 2'(pcs), 1'(iord), 1'(mr), 1'(mw), 1'(irw), 1'(rd),
                1'(m2r), 1'(rw), 1'(sa), 2'(sb), 2'(op)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic look(input string tag, input state_t st, input logic [15:0] exp_ctl);
        #1;
        check({tag, ".state"}, 32'(state_o), 32'(st));
        check({tag, ".ctl"}, 32'(ctl_obs), 32'(exp_ctl));
    endtask

    logic [15:0] c_zero, c_fetch_rdy, c_fetch_wait, c_decode, c_r_exec, c_r_wb, c_i_add, c_i_or;
    logic [15:0] c_i_wb, c_mem_addr, c_mem_rd, c_mem_wr, c_lw_wb, c_branch, c_jump, c_jal;

    initial begin
        //                    pcw pcc pcs iord mr mw irw rd m2r rw sa sb op
        c_zero       = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        c_fetch_rdy  = ctl(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1);
        c_fetch_wait = ctl(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        c_decode     = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1);
        c_r_exec     = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        c_r_wb       = ctl(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        c_i_add      = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1);
        c_i_or       = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2);
        c_i_wb       = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        c_mem_addr   = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1);
        c_mem_rd     = ctl(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        c_mem_wr     = ctl(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        c_lw_wb      = ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        c_branch     = ctl(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
        c_jump       = ctl(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        c_jal        = ctl(1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        rst_i = 1'b1; start_i = 1'b0; mem_ready_i = 1'b0; op_i = 6'b000000;
        step(); step();
        look("reset", ST_IDLE, c_zero);
        check("reset.mem_err", 32'(mem_err_o), 32'd0);
        check("reset.illegal", 32'(illegal_o), 32'd0);
        rst_i = 1'b0;

        // R-type
        start_i = 1'b1; mem_ready_i = 1'b1; op_i = OP_RTYPE;
        step(); start_i = 1'b0;
        look("r.fetch", ST_FETCH, c_fetch_rdy);
        step(); look("r.decode", ST_DECODE, c_decode);
        step(); look("r.exec", ST_R_EXEC, c_r_exec);
        step(); look("r.wb", ST_R_WB, c_r_wb);

        // lw with three not-ready cycles in MEM_RD
        step(); op_i = OP_LW; look("lw.fetch", ST_FETCH, c_fetch_rdy);
        step(); look("lw.decode", ST_DECODE, c_decode);
        step(); look("lw.addr", ST_MEM_ADDR, c_mem_addr);
        for (int k = 1; k <= 4; k++) begin
            step();
            mem_ready_i = (k == 4);
            look($sformatf("lw.mem_rd%0d", k), ST_MEM_RD, c_mem_rd);
        end
        step(); look("lw.wb", ST_LW_WB, c_lw_wb);

        // sw
        step(); op_i = OP_SW; look("sw.fetch", ST_FETCH, c_fetch_rdy);
        step(); look("sw.decode", ST_DECODE, c_decode);
        step(); look("sw.addr", ST_MEM_ADDR, c_mem_addr);
        step(); look("sw.mem_wr", ST_MEM_WR, c_mem_wr);

        // beq: one cycle of conditional PC load
        step(); op_i = OP_BEQ; look("beq.fetch", ST_FETCH, c_fetch_rdy);
        step(); look("beq.decode", ST_DECODE, c_decode);
        step(); look("beq.branch", ST_BRANCH, c_branch);

        // addi and ori
        step(); op_i = OP_ADDI; look("beq.after", ST_FETCH, c_fetch_rdy);
        step(); look("addi.decode", ST_DECODE, c_decode);
        step(); look("addi.exec", ST_I_EXEC, c_i_add);
        step(); look("addi.wb", ST_I_WB, c_i_wb);
        step(); op_i = OP_ORI; look("ori.fetch", ST_FETCH, c_fetch_rdy);
        step(); look("ori.decode", ST_DECODE, c_decode);
        step(); look("ori.exec", ST_I_EXEC, c_i_or);
        step(); look("ori.wb", ST_I_WB, c_i_wb);

        // j
        step(); op_i = OP_J; look("j.fetch", ST_FETCH, c_fetch_rdy);
        step(); look("j.decode", ST_DECODE, c_decode);
        step(); look("j.jump", ST_JUMP, c_jump);

        // jal opcode: link in JAL state when enabled, otherwise an illegal pulse
        step(); op_i = OP_JAL; look("jal.fetch", ST_FETCH, c_fetch_rdy);
        step(); look("jal.decode", ST_DECODE, c_decode);
        check("jal.decode.illegal", 32'(illegal_o), 32'd0);
`ifdef JAL_EN
        step(); look("jal.jal", ST_JAL, c_jal);
        check("jal.link", 32'(jal_link_o), 32'd1);
        check("jal.illegal", 32'(illegal_o), 32'd0);
        step(); look("jal.after", ST_FETCH, c_fetch_rdy);
        check("jal.after.link", 32'(jal_link_o), 32'd0);
`else
        step(); look("jal.illegal_fetch", ST_FETCH, c_fetch_rdy);
        check("jal.illegal", 32'(illegal_o), 32'd1);
`endif
        op_i = 6'b111111;
        step(); look("bad.decode", ST_DECODE, c_decode);
        check("bad.decode.illegal", 32'(illegal_o), 32'd0);
        step(); look("bad.fetch", ST_FETCH, c_fetch_rdy);
        check("bad.illegal", 32'(illegal_o), 32'd1);

        // ready arriving on the 15th wait cycle still completes the fetch
        op_i = OP_RTYPE;
        step(); check("pulse.end", 32'(illegal_o), 32'd0);
        step(); step(); mem_ready_i = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            mem_ready_i = (k == 15);
            look($sformatf("edge.fetch%0d", k), ST_FETCH, (k == 15) ? c_fetch_rdy : c_fetch_wait);
        end
        step(); look("edge.decode", ST_DECODE, c_decode);
        check("edge.mem_err", 32'(mem_err_o), 32'd0);

        // 15 not-ready cycles in FETCH time out to IDLE with no IR write
        step(); step(); mem_ready_i = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            look($sformatf("tmo.fetch%0d", k), ST_FETCH, c_fetch_wait);
            check($sformatf("tmo.err%0d", k), 32'(mem_err_o), 32'd0);
        end
        step(); look("tmo.idle", ST_IDLE, c_zero);
        check("tmo.mem_err", 32'(mem_err_o), 32'd1);
        step(); look("tmo.hold", ST_IDLE, c_zero);
        check("tmo.sticky", 32'(mem_err_o), 32'd1);

        // reset in the middle of MEM_RD aborts and clears the sticky error
        start_i = 1'b1; mem_ready_i = 1'b1; op_i = OP_LW;
        step(); start_i = 1'b0;
        step(); step(); mem_ready_i = 1'b0;
        step(); look("rst.mem_rd", ST_MEM_RD, c_mem_rd);
        rst_i = 1'b1;
        step(); look("rst.abort", ST_IDLE, c_zero);
        check("rst.mem_err", 32'(mem_err_o), 32'd0);
        check("rst.illegal", 32'(illegal_o), 32'd0);
        rst_i = 1'b0;
        step(); look("rst.hold", ST_IDLE, c_zero);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
